stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
- Two-requester front end for the 5-entry, 4-bit structural stack.
- Sits between two client blocks and one stack instance.
- Round-robin arbitrates requests, drives the stack's COMMAND/INDEX/I_DATA for exactly one clock, and returns O_DATA to the winner after a fixed read latency.
- Tracks occupancy so that overflow, underflow and out-of-range get are rejected, not silently wrapped.

Parameters:
- DEPTH, 5, stack entries; occupancy saturates here.
- DW, 4, data width.
- IW, 3, index width.
- RD_LAT, 1, CLK cycles from command edge to valid stack O_DATA (0..3).

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- CLR  input  1  clear-stack request pulse; sampled in IDLE only.
- REQ0, REQ1  input  1  request from client 0/1; held high until its ACK.
- CMD0, CMD1  input  2  client op: 00 nop, 01 push, 10 pop, 11 get.
- IDX0, IDX1  input  IW  get index, 0 = top.
- WDATA0, WDATA1  input  DW  push data.
- ACK0, ACK1  output  1  one-cycle completion pulse.
- RDATA  output  DW  result, valid while ACKx is high; 0 otherwise.
- ERR  output  1  op rejected, valid while ACKx is high.
- COUNT  output  3  current occupancy, 0..DEPTH.
- S_RESET  output  1  to stack RESET, active high.
- S_COMMAND  output  2  to stack COMMAND.
- S_INDEX  output  IW  to stack INDEX.
- S_I_DATA  output  DW  to stack I_DATA.
- S_O_DATA  input  DW  from stack O_DATA.

Behaviour:
- Reset (RESET_N low, any time, mid-op included): state IDLE, ACK0/1=0, RDATA=0, ERR=0, COUNT=0, last_grant=1 (client 0 wins first tie), S_COMMAND=00, S_INDEX=0, S_I_DATA=0. S_RESET = ~RESET_N | (state==CLEAR), so the stack is cleared with the controller. In-flight op is dropped with no ACK.
- States: IDLE, CLEAR, ISSUE, WAIT, RESP.
- IDLE transitions:
  - CLR high -> CLEAR. CLR has priority over REQ.
  - Else if any REQ high, grant it. Tie -> the client other than last_grant.
  - On grant, latch the winner's CMD/IDX/WDATA and update last_grant.
  - Legality check on the latched op:
    - push: illegal if COUNT==DEPTH.
    - pop: illegal if COUNT==0.
    - get: illegal if IDX>=COUNT.
    - nop: always legal, never issued.
  - Illegal op or nop -> RESP with ERR=1 (illegal) or ERR=0 (nop), RDATA=0.
  - Legal push/pop/get -> ISSUE.
- CLEAR: one cycle, S_RESET=1, COUNT<=0 -> IDLE.
- ISSUE: one cycle. S_COMMAND/S_INDEX/S_I_DATA driven from the latched op; all are 00/0/0 in every other state. COUNT +1 on push, -1 on pop at the end of the cycle. Next state is WAIT if RD_LAT>0, else RESP.
- WAIT: RD_LAT cycles, counted with a down-counter. Capture S_O_DATA on the last WAIT cycle for pop/get.
- RESP: one cycle. ACK of the granted client =1. RDATA = captured value (0 for push/nop/error). ERR as determined. Next state IDLE.
- Handshake:
  - Client drops REQ on the edge where it samples ACK high, or changes its op.
  - A REQ held through IDLE after its ACK is treated as a new request.
  - CMD/IDX/WDATA are don't-care after the grant cycle.
- Latency from REQ high in IDLE:
  - legal push/pop/get, RD_LAT=1: ACK in cycle 3.
  - illegal op or nop: ACK in cycle 1.
- Only one op is outstanding at any time. The non-granted REQ waits without loss.
- A CLR arriving outside IDLE is ignored; the client must hold it until IDLE.
- COUNT never wraps: push at DEPTH and pop at 0 are rejected.

Decomposition:
- Package stack_arb_pkg holds:
  - enum of ops: OP_NOP, OP_PUSH, OP_POP, OP_GET.
  - FSM state enum.
  - DEPTH/DW/IW defaults.
- One sub-module: rr_arbiter2, a 2-way round-robin picker with a last_grant register and a grant-enable input.
- FSM, occupancy counter and latency counter stay in the top level.

Test Plan:
- Reset then REQ0 push 0001, REQ0 push 0011 (RD_LAT=1) -> ACK0 in cycle 3 of each with ERR=0; COUNT 1 then 2; S_COMMAND=01 for exactly one cycle each.
- Get IDX=0 and IDX=1, then IDX=2 with COUNT=2 -> RDATA 0011, 0011→0001 ordering verified (IDX0=0011, IDX1=0001); IDX=2 gives ERR=1 in cycle 1 and no S_COMMAND activity.
- Push 5 values to COUNT=5, then a 6th push -> ERR=1, COUNT stays 5. Then 5 pops return the values in LIFO order, and a 6th pop -> ERR=1, RDATA=0, COUNT=0.
- REQ0 and REQ1 both held, 4 ops each -> grants alternate 0,1,0,1…; first grant is client 0 after reset; no ACK is lost or duplicated.
- CLR pulse in IDLE with COUNT=3 -> S_RESET high for one cycle, COUNT=0, and a subsequent get IDX=0 -> ERR=1.
- RESET_N low during WAIT of a pop -> all outputs 0 immediately (asynchronously), S_RESET high, no ACK. After release, push 0110 then get 0 -> RDATA 0110.

Source files
------------

// File: rtl/stack_arb_pkg.sv
// Shared types and default sizes for the two-client stack arbiter.
package stack_arb_pkg;

  localparam int DEPTH_DEF = 5;
  localparam int DW_DEF    = 4;
  localparam int IW_DEF    = 3;

  // Client operation codes, identical to the stack COMMAND encoding.
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_GET  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/stack_arbiter_rr.sv
// Two-way round-robin picker; on a tie the client that did not win last time is chosen.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic last_grant
);

  logic pick1;

  // Client 1 wins when it is alone, or on a tie when client 0 won last.
  always_comb begin
    pick1 = req1 & (~req0 | ~last_grant);
    gnt1  = en & pick1;
    gnt0  = en & req0 & ~pick1;
  end

  // Remember the most recent winner; after reset client 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_grant <= gnt1;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Two-requester front end for a small structural stack: arbitrates, checks
// occupancy, issues one stack command and returns the result to the winner.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DW     = DW_DEF,
  parameter int IW     = IW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          CLR,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic [1:0]    CMD0,
  input  logic [1:0]    CMD1,
  input  logic [IW-1:0] IDX0,
  input  logic [IW-1:0] IDX1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          ACK0,
  output logic          ACK1,
  output logic [DW-1:0] RDATA,
  output logic          ERR,
  output logic [2:0]    COUNT,
  output logic          S_RESET,
  output logic [1:0]    S_COMMAND,
  output logic [IW-1:0] S_INDEX,
  output logic [DW-1:0] S_I_DATA,
  input  logic [DW-1:0] S_O_DATA
);

  localparam logic [1:0] LAT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_e        state_q, state_d;
  op_e           op_q, sel_op;
  logic [IW-1:0] idx_q, sel_idx;
  logic [DW-1:0] wdata_q, sel_wdata, rdata_q;
  logic          err_q, sel_issue, sel_err;
  logic [2:0]    count_q;
  logic [1:0]    lat_q;
  logic          grant_en, gnt0, gnt1, last_grant, granted, capture;

  // Occupancy rules: no push when full, no pop when empty, get only below the top COUNT entries.
  function automatic logic op_legal(input op_e op, input logic [IW-1:0] idx,
                                    input logic [2:0] cnt);
    logic ok;
    ok = 1'b1;
    case (op)
      OP_PUSH: ok = (int'(cnt) < DEPTH);
      OP_POP:  ok = (cnt != 3'd0);
      OP_GET:  ok = (int'(idx) < int'(cnt));
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Arbitration only happens in IDLE, and CLR takes priority over any request.
  assign grant_en = (state_q == ST_IDLE) && !CLR;

  rr_arbiter2 u_arb (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .en         (grant_en),
    .req0       (REQ0),
    .req1       (REQ1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .last_grant (last_grant)
  );

  // Select the winner's operation and classify it before latching.
  always_comb begin
    granted   = gnt0 | gnt1;
    sel_op    = op_e'(gnt1 ? CMD1 : CMD0);
    sel_idx   = gnt1 ? IDX1 : IDX0;
    sel_wdata = gnt1 ? WDATA1 : WDATA0;
    sel_issue = (sel_op != OP_NOP) && op_legal(sel_op, sel_idx, count_q);
    sel_err   = (sel_op != OP_NOP) && !op_legal(sel_op, sel_idx, count_q);
    capture   = ((op_q == OP_POP) || (op_q == OP_GET)) &&
                (((state_q == ST_WAIT) && (lat_q == 2'd0)) ||
                 ((state_q == ST_ISSUE) && (RD_LAT == 0)));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (CLR)          state_d = ST_CLEAR;
        else if (granted) state_d = sel_issue ? ST_ISSUE : ST_RESP;
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_ISSUE: state_d = (RD_LAT > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (lat_q == 2'd0) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Occupancy and read-latency counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= 3'd0;
      lat_q   <= 2'd0;
    end else begin
      if (state_q == ST_CLEAR) begin
        count_q <= 3'd0;
      end else if (state_q == ST_ISSUE) begin
        if (op_q == OP_PUSH)     count_q <= count_q + 3'd1;
        else if (op_q == OP_POP) count_q <= count_q - 3'd1;
      end
      if (state_q == ST_ISSUE)     lat_q <= LAT_INIT;
      else if (state_q == ST_WAIT) lat_q <= lat_q - 2'd1;
    end
  end

  // Latched operation and result; only observed through state-gated outputs.
  always_ff @(posedge CLK) begin
    if (granted) begin
      op_q    <= sel_op;
      idx_q   <= sel_idx;
      wdata_q <= sel_wdata;
      err_q   <= sel_err;
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= S_O_DATA;
    end
  end

  // Client and stack outputs, all zero outside their owning state.
  always_comb begin
    ACK0      = (state_q == ST_RESP) && !last_grant;
    ACK1      = (state_q == ST_RESP) && last_grant;
    RDATA     = (state_q == ST_RESP) ? rdata_q : '0;
    ERR       = (state_q == ST_RESP) && err_q;
    COUNT     = count_q;
    S_RESET   = !RESET_N || (state_q == ST_CLEAR);
    S_COMMAND = (state_q == ST_ISSUE) ? op_q : 2'b00;
    S_INDEX   = (state_q == ST_ISSUE) ? idx_q : '0;
    S_I_DATA  = (state_q == ST_ISSUE) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural stack behind the DUT, queue scoreboard
// checked on every cycle, and directed client transactions with literal results.
module tb_stack_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       CLR = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [1:0] CMD0 = 2'd0, CMD1 = 2'd0;
  logic [2:0] IDX0 = 3'd0, IDX1 = 3'd0;
  logic [3:0] WDATA0 = 4'd0, WDATA1 = 4'd0;
  logic       ACK0, ACK1, ERR, S_RESET;
  logic [3:0] RDATA, S_I_DATA;
  logic [2:0] COUNT, S_INDEX;
  logic [1:0] S_COMMAND;
  logic [3:0] S_O_DATA = 4'd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  stack_arbiter #(.RD_LAT(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLR(CLR),
    .REQ0(REQ0), .REQ1(REQ1), .CMD0(CMD0), .CMD1(CMD1),
    .IDX0(IDX0), .IDX1(IDX1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .ERR(ERR), .COUNT(COUNT),
    .S_RESET(S_RESET), .S_COMMAND(S_COMMAND), .S_INDEX(S_INDEX),
    .S_I_DATA(S_I_DATA), .S_O_DATA(S_O_DATA)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stack instance stand-in: array with pointer, registered O_DATA one cycle after the command.
  logic [3:0] smem [0:7];
  int sp = 0;
  always @(posedge CLK) begin
    S_O_DATA <= 4'd0;
    if (S_RESET) sp <= 0;
    else case (S_COMMAND)
      2'b01: begin smem[sp & 7] <= S_I_DATA; sp <= sp + 1; end
      2'b10: begin S_O_DATA <= smem[(sp - 1) & 7]; sp <= sp - 1; end
      2'b11: S_O_DATA <= smem[(sp - 1 - int'(S_INDEX)) & 7];
      default: ;
    endcase
  end

  // Scoreboard: queue with the top of stack at the front.
  logic [3:0] mq[$];
  int         ack_log[$];
  int         issues = 0;
  logic [1:0] li_cmd = 2'd0;
  logic [2:0] li_idx = 3'd0;
  logic [3:0] li_wd = 4'd0;
  int         mc;
  logic [1:0] mcmd;
  logic [2:0] midx;
  logic [3:0] mwd, m_rd;
  logic       m_err, m_iss;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      mq.delete();
      issues = 0;
      chk("rst_sreset", int'(S_RESET), 1);
      chk("rst_ack", int'({ACK1, ACK0}), 0);
      chk("rst_rdata", int'(RDATA), 0);
      chk("rst_err", int'(ERR), 0);
      chk("rst_count", int'(COUNT), 0);
      chk("rst_sbus", int'({S_COMMAND, S_INDEX, S_I_DATA}), 0);
    end else begin
      if (S_RESET) mq.delete();
      if (S_COMMAND != 2'b00) begin
        issues++;
        li_cmd = S_COMMAND; li_idx = S_INDEX; li_wd = S_I_DATA;
      end else begin
        chk("idle_sbus", int'({S_INDEX, S_I_DATA}), 0);
      end
      if (ACK0 && ACK1) begin
        chk("ack_onehot", 2, 1);
      end else if (ACK0 || ACK1) begin
        mc   = ACK1 ? 1 : 0;
        mcmd = ACK1 ? CMD1 : CMD0;
        midx = ACK1 ? IDX1 : IDX0;
        mwd  = ACK1 ? WDATA1 : WDATA0;
        m_err = 1'b0; m_rd = 4'd0;
        case (mcmd)
          2'b01: if (mq.size() >= 5) m_err = 1'b1; else mq.push_front(mwd);
          2'b10: if (mq.size() == 0) m_err = 1'b1; else m_rd = mq.pop_front();
          2'b11: if (int'(midx) >= mq.size()) m_err = 1'b1; else m_rd = mq[midx];
          default: ;
        endcase
        m_iss = !m_err && (mcmd != 2'b00);
        chk("model_err", int'(ERR), int'(m_err));
        chk("model_rdata", int'(RDATA), int'(m_rd));
        chk("model_count", int'(COUNT), mq.size());
        chk("model_issue_cnt", issues, int'(m_iss));
        if (m_iss) begin
          chk("model_scmd", int'(li_cmd), int'(mcmd));
          if (mcmd == 2'b11) chk("model_sindex", int'(li_idx), int'(midx));
          if (mcmd == 2'b01) chk("model_sidata", int'(li_wd), int'(mwd));
        end
        issues = 0;
        ack_log.push_back(mc);
      end else begin
        chk("noack_rdata", int'(RDATA), 0);
        chk("noack_err", int'(ERR), 0);
      end
    end
  end

  // One client transaction, started at posedge+1 with the DUT in IDLE; exp_lat < 0 skips the latency check.
  task automatic do_op(input int c, input logic [1:0] cmd, input logic [2:0] idx,
                       input logic [3:0] wd, input int exp_lat, input logic [3:0] exp_rd,
                       input logic exp_err, input int exp_cnt);
    int n;
    bit got;
    if (c == 0) begin REQ0 = 1'b1; CMD0 = cmd; IDX0 = idx; WDATA0 = wd; end
    else        begin REQ1 = 1'b1; CMD1 = cmd; IDX1 = idx; WDATA1 = wd; end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge CLK);
      n++;
      if ((c == 0) ? ACK0 : ACK1) got = 1'b1;
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
    end else begin
      if (exp_lat >= 0) chk("latency", n - 1, exp_lat);
      chk("rdata", int'(RDATA), int'(exp_rd));
      chk("err", int'(ERR), int'(exp_err));
      chk("count", int'(COUNT), exp_cnt);
    end
    @(posedge CLK); #1;
    if (c == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
  endtask

  task automatic pulse_reset();
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    #2;
    pulse_reset();

    // Two pushes, then gets by index, then an out-of-range get and a nop.
    do_op(0, 2'd1, 3'd0, 4'h1, 3, 4'h0, 1'b0, 1);
    do_op(0, 2'd1, 3'd0, 4'h3, 3, 4'h0, 1'b0, 2);
    do_op(0, 2'd3, 3'd0, 4'h0, 3, 4'h3, 1'b0, 2);
    do_op(0, 2'd3, 3'd1, 4'h0, 3, 4'h1, 1'b0, 2);
    do_op(0, 2'd3, 3'd2, 4'h0, 1, 4'h0, 1'b1, 2);
    do_op(0, 2'd0, 3'd0, 4'h9, 1, 4'h0, 1'b0, 2);

    // Fill to DEPTH, overflow, drain in LIFO order, underflow.
    do_op(0, 2'd1, 3'd0, 4'h5, 3, 4'h0, 1'b0, 3);
    do_op(0, 2'd1, 3'd0, 4'h7, 3, 4'h0, 1'b0, 4);
    do_op(0, 2'd1, 3'd0, 4'h9, 3, 4'h0, 1'b0, 5);
    do_op(0, 2'd1, 3'd0, 4'hB, 1, 4'h0, 1'b1, 5);
    do_op(1, 2'd2, 3'd0, 4'h0, 3, 4'h9, 1'b0, 4);
    do_op(1, 2'd2, 3'd0, 4'h0, 3, 4'h7, 1'b0, 3);
    do_op(0, 2'd2, 3'd0, 4'h0, 3, 4'h5, 1'b0, 2);
    do_op(0, 2'd2, 3'd0, 4'h0, 3, 4'h3, 1'b0, 1);
    do_op(0, 2'd2, 3'd0, 4'h0, 3, 4'h1, 1'b0, 0);
    do_op(0, 2'd2, 3'd0, 4'h0, 1, 4'h0, 1'b1, 0);

    // Both clients held continuously after reset: grants must alternate starting with 0.
    pulse_reset();
    ack_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          do_op(0, 2'd1, 3'd0, 4'(i + 1), -1, 4'h0, 1'b0, i + 1);
      end
      begin
        for (int j = 0; j < 4; j++)
          do_op(1, 2'd3, 3'd0, 4'h0, -1, 4'(j + 1), 1'b0, j + 1);
      end
    join
    chk("rr_ack_total", ack_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < ack_log.size()) chk("rr_order", ack_log[k], k % 2);
    end

    // CLR in IDLE with three entries.
    do_op(0, 2'd2, 3'd0, 4'h0, 3, 4'h4, 1'b0, 3);
    CLR = 1'b1;
    @(negedge CLK);
    chk("clr_sreset_idle", int'(S_RESET), 0);
    @(posedge CLK); #1 CLR = 1'b0;
    chk("clr_sreset", int'(S_RESET), 1);
    @(posedge CLK); #1;
    chk("clr_sreset_off", int'(S_RESET), 0);
    chk("clr_count", int'(COUNT), 0);
    do_op(0, 2'd3, 3'd0, 4'h0, 1, 4'h0, 1'b1, 0);

    // Asynchronous reset while a pop waits for stack data.
    do_op(0, 2'd1, 3'd0, 4'h7, 3, 4'h0, 1'b0, 1);
    REQ0 = 1'b1; CMD0 = 2'd2;
    @(posedge CLK); #1;
    chk("pop_issue", int'(S_COMMAND), 2);
    @(posedge CLK); #3;
    RESET_N = 1'b0;
    #1;
    chk("arst_ack", int'({ACK1, ACK0}), 0);
    chk("arst_rdata", int'(RDATA), 0);
    chk("arst_err", int'(ERR), 0);
    chk("arst_count", int'(COUNT), 0);
    chk("arst_sbus", int'({S_COMMAND, S_INDEX, S_I_DATA}), 0);
    chk("arst_sreset", int'(S_RESET), 1);
    REQ0 = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(posedge CLK); #1;
    chk("arst_no_late_ack", int'({ACK1, ACK0}), 0);
    do_op(0, 2'd1, 3'd0, 4'h6, 3, 4'h0, 1'b0, 1);
    do_op(0, 2'd3, 3'd0, 4'h0, 3, 4'h6, 1'b0, 1);

    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
